// File: rtl/group_ctrl_pkg.sv
// Shared types and constants for the LED group controller.
// Holds the group FSM state encoding and the phase counter width.
package led_pkg;

    localparam int PHASE_W = 8;

    typedef enum logic [1:0] {
        SLEEP = 2'b00,
        DIM   = 2'b01,
        BLINK = 2'b10
    } grp_state_e;

endpackage

// File: rtl/group_ctrl_tick_gen.sv
// PWM prescaler: counts 0..PRESCALE-1 while enabled, one-cycle tick on the last count.
// Dropping en clears the count, so a restart always begins a full prescale interval.
module tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/group_ctrl.sv
// Group dimming/blinking controller: shadowed duty/period, 256-step phase, registered output.
// Define GROUP_BLINK_EN to build the BLINK mode; otherwise only SLEEP and DIM exist.
module group_ctrl
    import led_pkg::*;
#(
    parameter int PRESCALE  = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sleep,
    input  logic         dmblnk,
    input  logic [7:0]   grppwm,
    input  logic [7:0]   grpfreq,
    output logic         group_out,
    output logic         period_start,
    output logic [1:0]   state
);

    grp_state_e cur_state;
    grp_state_e nxt_state;

    logic               active;
    logic               transition;
    logic               enter;
    logic               run_en;
    logic               tick;
    logic               step;
    logic               wrap;
    logic               load;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] duty_sh;

    // sleep overrides everything; otherwise the requested mode is the target state
    always_comb begin
        nxt_state = cur_state;
        if (sleep) begin
            nxt_state = SLEEP;
        end else begin
`ifdef GROUP_BLINK_EN
            nxt_state = dmblnk ? BLINK : DIM;
`else
            nxt_state = DIM;
`endif
        end
    end

    assign active     = (cur_state != SLEEP);
    assign transition = (nxt_state != cur_state);
    assign enter      = transition && (nxt_state != SLEEP);
    // counters only run in a settled active state; any transition clears them
    assign run_en     = active && !transition;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .tick (tick)
    );

`ifdef GROUP_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] UNIT_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] unit_cnt;
    logic [7:0]    freq_cnt;
    logic [7:0]    freq_sh;
    logic          unit_last;
    logic          freq_last;

    assign unit_last = (unit_cnt == UNIT_LAST);
    assign freq_last = (freq_cnt == freq_sh);

    always_ff @(posedge clk) begin
        if (rst || !run_en) begin
            unit_cnt <= '0;
            freq_cnt <= '0;
        end else if ((cur_state == BLINK) && tick) begin
            if (unit_last) begin
                unit_cnt <= '0;
                freq_cnt <= freq_last ? '0 : freq_cnt + 8'd1;
            end else begin
                unit_cnt <= unit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_sh <= '0;
        end else if (load) begin
            freq_sh <= grpfreq;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{dmblnk, grpfreq} ^ (BLINK_DIV < 1);
`endif

    always_comb begin
        step = 1'b0;
        if (cur_state == DIM) begin
            step = tick;
        end
`ifdef GROUP_BLINK_EN
        else if (cur_state == BLINK) begin
            step = tick && unit_last && freq_last;
        end
`endif
    end

    assign wrap = step && (phase == '1);
    assign load = enter || wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= SLEEP;
            phase        <= '0;
            duty_sh      <= '0;
            group_out    <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            group_out    <= active && (nxt_state != SLEEP) && (phase < duty_sh);
            period_start <= load;
            if (!run_en) begin
                phase <= '0;
            end else if (step) begin
                phase <= phase + PHASE_W'(1);
            end
            if (load) begin
                duty_sh <= grppwm;
            end
        end
    end

    assign state = cur_state;

endmodule
